// File: rtl/serial_word_deser_pkg.sv
// Shared types for the serial word deserializer.
// State encoding and counter sizing helper.
package serial_word_deser_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    HOLD
  } deser_state_t;

  localparam int DEF_WIDTH = 8;

  function automatic int cnt_width(input int w);
    return $clog2(w);
  endfunction

endpackage

// File: rtl/serial_word_deser_shift_reg_lsb.sv
// LSB-first shift-in register: new bits enter at the MSB.
// After WIDTH shifts the first bit received sits in bit 0.
module shift_reg_lsb
  import serial_word_deser_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             en,
  input  logic             din,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] nxt
);

  assign nxt = {din, q[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      q <= '0;
    end else if (en) begin
      q <= nxt;
    end
  end

endmodule

// File: rtl/serial_word_deser.sv
// Serial-to-parallel word receiver with valid/ready output.
// Even parity bit enabled by SERIAL_WORD_DESER_PARITY_EN.
module serial_word_deser
  import serial_word_deser_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             sin_en,
  input  logic             sin,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             parity_err,
  output logic             overrun
);

  localparam int CW = cnt_width(WIDTH);

  deser_state_t state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [WIDTH-1:0] shreg, shnxt, word;
  logic shift_en, start, load, take, lost;
  logic last, sr_clr_n;

  assign last     = cnt == CW'(WIDTH - 1);
  assign sr_clr_n = reset_n & ~start;

  shift_reg_lsb #(.WIDTH(WIDTH)) u_sr (
    .clk   (clk),
    .clr_n (sr_clr_n),
    .en    (shift_en),
    .din   (sin),
    .q     (shreg),
    .nxt   (shnxt)
  );

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    shift_en = 1'b0;
    start    = 1'b0;
    load     = 1'b0;
    take     = 1'b0;
    lost     = 1'b0;
    unique case (state)
      IDLE: begin
        if (sin_en && !sin) begin
          start    = 1'b1;
          cnt_nx   = '0;
          state_nx = DATA;
        end
      end
      DATA: begin
        if (sin_en) begin
          shift_en = 1'b1;
          cnt_nx   = cnt + CW'(1);
          if (last) begin
`ifdef SERIAL_WORD_DESER_PARITY_EN
            state_nx = PARITY;
`else
            load     = 1'b1;
            state_nx = HOLD;
`endif
          end
        end
      end
      PARITY: begin
        if (sin_en) begin
          load     = 1'b1;
          state_nx = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          take = 1'b1;
          // A start strobe alongside the transfer begins the next frame.
          if (sin_en && !sin) begin
            start    = 1'b1;
            cnt_nx   = '0;
            state_nx = DATA;
          end else begin
            state_nx = IDLE;
          end
        end else if (sin_en && !sin) begin
          lost = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

`ifdef SERIAL_WORD_DESER_PARITY_EN
  logic unused_shnxt;
  assign unused_shnxt = ^shnxt;
  assign word = shreg;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      parity_err <= 1'b0;
    end else if (load) begin
      parity_err <= (^shreg) ^ sin;
    end
  end
`else
  // Last data bit is loaded on the same edge it is shifted in.
  assign word       = shnxt;
  assign parity_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (load) begin
        out_data  <= word;
        out_valid <= 1'b1;
      end else if (take) begin
        out_valid <= 1'b0;
      end
      if (lost) begin
        overrun <= 1'b1;
      end
    end
  end

endmodule
